// File: rtl/frame_dump_pkg.sv
// frame_dump_pkg: shared state encoding, framing constants and byte helpers
// for the frame-dump controller.
package frame_dump_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HDR   = 2'd1,
    FETCH = 2'd2,
    SEND  = 2'd3
  } state_t;

  // Frame-start marker pair and the value pixels are clipped to so the
  // marker byte can never appear inside pixel data.
  localparam logic [7:0] SYNC0 = 8'hFF;
  localparam logic [7:0] SYNC1 = 8'h00;
  localparam logic [7:0] CLIP  = 8'hFE;

  // Header byte by position: sync pair followed by frame dimensions.
  function automatic logic [7:0] hdr_byte(input logic [1:0] idx,
                                          input logic [7:0] w,
                                          input logic [7:0] h);
    logic [7:0] b;
    case (idx)
      2'd0:    b = SYNC0;
      2'd1:    b = SYNC1;
      2'd2:    b = w;
      default: b = h;
    endcase
    return b;
  endfunction

  // Keep pixel data out of the sync marker's code space.
  function automatic logic [7:0] clip_pixel(input logic [7:0] d);
    return (d == SYNC0) ? CLIP : d;
  endfunction

endpackage

// File: rtl/trigger_debounce.sv
// trigger_debounce: registers the raw button level and accepts a press only
// after it has been low for DEBOUNCE consecutive cycles. The parent gates the
// accept with its IDLE state.
module trigger_debounce #(
  parameter int DEBOUNCE = 16383
) (
  input  logic clock,
  input  logic reset,
  input  logic start_i,
  output logic accept_o
);

  localparam int DW = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] SAT = DW'(DEBOUNCE);

  logic          start_q;
  logic [DW-1:0] cnt_q, cnt_d;

  // Low-time counter: cleared while the registered level is high, saturates.
  always_comb begin
    cnt_d = cnt_q;
    if (start_q)
      cnt_d = '0;
    else if (cnt_q != SAT)
      cnt_d = cnt_q + 1'b1;
  end

  // Input register and counter state.
  always_ff @(posedge clock) begin
    if (reset) begin
      start_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      start_q <= start_i;
      cnt_q   <= cnt_d;
    end
  end

  // Counter still holds the pre-press low time on the first high cycle.
  assign accept_o = start_q && (cnt_q == SAT);

endmodule

// File: rtl/frame_dump_ctrl.sv
// frame_dump_ctrl: raster-scans a frame buffer read port and streams each
// pixel byte to a UART, paced by a post-busy holdoff.
// Optional framing header (FF,00,WIDTH,HEIGHT plus FF->FE pixel clipping)
// is compiled in when FRAME_DUMP_HEADER_EN is defined.
module frame_dump_ctrl
  import frame_dump_pkg::*;
#(
  parameter int WIDTH        = 40,
  parameter int HEIGHT       = 30,
  parameter int X_BITS       = 6,
  parameter int Y_BITS       = 5,
  parameter int READ_LATENCY = 1,
  parameter int HOLDOFF      = 8191,
  parameter int DEBOUNCE     = 16383
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              continuous,
  input  logic              abort,
  output logic [X_BITS-1:0] read_x,
  output logic [Y_BITS-1:0] read_y,
  input  logic [7:0]        read_data,
  input  logic              tx_busy,
  output logic              tx_write,
  output logic [7:0]        tx_data,
  output logic              active,
  output logic              frame_done
);

  localparam int HW = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
  localparam logic [HW-1:0]     HOLD_SAT = HW'(HOLDOFF);
  localparam logic [X_BITS-1:0] X_LAST   = X_BITS'(WIDTH - 1);
  localparam logic [Y_BITS-1:0] Y_LAST   = Y_BITS'(HEIGHT - 1);
  localparam logic [2:0]        LAT_LAST = 3'(READ_LATENCY);
`ifdef FRAME_DUMP_HEADER_EN
  localparam state_t FIRST = HDR;
`else
  localparam state_t FIRST = FETCH;
`endif

  state_t            state_q;
  logic [X_BITS-1:0] x_q;
  logic [Y_BITS-1:0] y_q;
  logic [2:0]        lat_q;
  logic              tx_write_q, active_q, frame_done_q;
  logic [7:0]        tx_data_q;
  logic [HW-1:0]     hold_q, hold_d;
  logic              accept, ready, last_px;
`ifdef FRAME_DUMP_HEADER_EN
  logic [1:0]        hdr_idx_q;
`endif

  trigger_debounce #(.DEBOUNCE(DEBOUNCE)) u_trig (
    .clock    (clock),
    .reset    (reset),
    .start_i  (start),
    .accept_o (accept)
  );

  // Holdoff: idle time since the UART was last busy or last written.
  always_comb begin
    hold_d = hold_q;
    if (tx_busy || tx_write_q)
      hold_d = '0;
    else if (hold_q != HOLD_SAT)
      hold_d = hold_q + 1'b1;
  end

  // Holdoff counter state.
  always_ff @(posedge clock) begin
    if (reset) hold_q <= '0;
    else       hold_q <= hold_d;
  end

  assign ready   = (hold_q == HOLD_SAT) && !tx_busy && !tx_write_q;
  assign last_px = (x_q == X_LAST) && (y_q == Y_LAST);

  // Dump FSM with registered strobes; abort overrides every transition.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      lat_q        <= '0;
      tx_write_q   <= 1'b0;
      tx_data_q    <= '0;
      active_q     <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef FRAME_DUMP_HEADER_EN
      hdr_idx_q    <= '0;
`endif
    end else begin
      tx_write_q   <= 1'b0;
      frame_done_q <= 1'b0;
      if (abort) begin
        state_q  <= IDLE;
        active_q <= 1'b0;
        x_q      <= '0;
        y_q      <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (accept) begin
              x_q      <= '0;
              y_q      <= '0;
              lat_q    <= '0;
              active_q <= 1'b1;
              state_q  <= FIRST;
`ifdef FRAME_DUMP_HEADER_EN
              hdr_idx_q <= '0;
`endif
            end
          end
`ifdef FRAME_DUMP_HEADER_EN
          HDR: begin
            if (ready) begin
              tx_write_q <= 1'b1;
              tx_data_q  <= hdr_byte(hdr_idx_q, 8'(WIDTH), 8'(HEIGHT));
              hdr_idx_q  <= hdr_idx_q + 2'd1;
              if (hdr_idx_q == 2'd3) begin
                lat_q   <= '0;
                state_q <= FETCH;
              end
            end
          end
`endif
          FETCH: begin
            // Address has been stable since entry; data is valid once the
            // latency count has elapsed.
            if (lat_q == LAT_LAST) begin
`ifdef FRAME_DUMP_HEADER_EN
              tx_data_q <= clip_pixel(read_data);
`else
              tx_data_q <= read_data;
`endif
              state_q <= SEND;
            end else begin
              lat_q <= lat_q + 3'd1;
            end
          end
          SEND: begin
            if (ready) begin
              tx_write_q <= 1'b1;
              lat_q      <= '0;
              if (last_px) begin
                frame_done_q <= 1'b1;
                x_q          <= '0;
                y_q          <= '0;
                active_q     <= continuous;
                state_q      <= continuous ? FIRST : IDLE;
`ifdef FRAME_DUMP_HEADER_EN
                hdr_idx_q    <= '0;
`endif
              end else begin
                if (x_q == X_LAST) begin
                  x_q <= '0;
                  y_q <= y_q + 1'b1;
                end else begin
                  x_q <= x_q + 1'b1;
                end
                state_q <= FETCH;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign read_x     = x_q;
  assign read_y     = y_q;
  assign tx_write   = tx_write_q;
  assign tx_data    = tx_data_q;
  assign active     = active_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_frame_dump_ctrl.sv
// tb_frame_dump_ctrl: directed bench for frame_dump_ctrl on a 4x3 frame with
// a {y,x} buffer model and a UART that stays busy 10 cycles per byte.
module tb_frame_dump_ctrl;

`ifdef FRAME_DUMP_HEADER_EN
  localparam int HN = 4;
`else
  localparam int HN = 0;
`endif
  localparam int FL = 12 + HN;

  logic       clk = 1'b0;
  logic       reset, start, continuous, abort;
  logic [1:0] read_x, read_y;
  logic [7:0] read_data;
  logic       tx_busy, tx_write, active, frame_done;
  logic [7:0] tx_data;
  int         bc = 0;
  int         cyc = 0;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] bytes[$];
  logic       fds[$];
  int         wcyc[$];
  int         viol = 0;
  int         last_busy = 0;
  logic       have_busy = 1'b0;
  logic       prev_wr = 1'b0;

  always #5 clk = ~clk;

  frame_dump_ctrl #(
    .WIDTH(4), .HEIGHT(3), .X_BITS(2), .Y_BITS(2),
    .READ_LATENCY(1), .HOLDOFF(3), .DEBOUNCE(7)
  ) dut (
    .clock(clk), .reset(reset), .start(start), .continuous(continuous),
    .abort(abort), .read_x(read_x), .read_y(read_y), .read_data(read_data),
    .tx_busy(tx_busy), .tx_write(tx_write), .tx_data(tx_data),
    .active(active), .frame_done(frame_done)
  );

  function automatic logic [7:0] pix(input logic [1:0] x, input logic [1:0] y);
`ifdef FRAME_DUMP_HEADER_EN
    if (x == 2'd1 && y == 2'd0) return 8'hFF;
`endif
    return {2'b00, y, 2'b00, x};
  endfunction

  function automatic logic [7:0] exp_byte(input int i);
    int p;
    logic [7:0] b;
`ifdef FRAME_DUMP_HEADER_EN
    if (i == 0) return 8'hFF;
    if (i == 1) return 8'h00;
    if (i == 2) return 8'h04;
    if (i == 3) return 8'h03;
`endif
    p = i - HN;
    b = {4'(p / 4), 4'(p % 4)};
`ifdef FRAME_DUMP_HEADER_EN
    if (b == 8'h01) b = 8'hFE;
`endif
    return b;
  endfunction

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    read_data <= pix(read_x, read_y);
    if (tx_write)    bc <= 10;
    else if (bc > 0) bc <= bc - 1;
  end
  assign tx_busy = (bc != 0);

  // Capture writes and flag strobe-legality / holdoff violations.
  always @(negedge clk) begin
    if (tx_write) begin
      bytes.push_back(tx_data);
      fds.push_back(frame_done);
      wcyc.push_back(cyc);
      if (tx_busy || prev_wr || (have_busy && (cyc - last_busy) < 4))
        viol <= viol + 1;
    end
    if (frame_done && !tx_write) viol <= viol + 1;
    prev_wr <= tx_write;
    if (tx_busy) begin
      last_busy <= cyc;
      have_busy <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic trig();
    tick(12);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int k = 0;
    while (bytes.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk("wait_bytes", 32'(bytes.size() >= n), 32'd1);
  endtask

  task automatic clear_log();
    bytes.delete();
    fds.delete();
    wcyc.delete();
  endtask

  function automatic int fd_count();
    int c = 0;
    foreach (fds[i]) if (fds[i]) c++;
    return c;
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; continuous = 1'b0; abort = 1'b0;
    tick(3);
    chk("rst_tx_write", 32'(tx_write), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_read_xy", {28'd0, read_y, read_x}, 0);
    chk("rst_active", 32'(active), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    reset = 1'b0;

    // Press too soon after reset: counter not yet saturated.
    tick(3);
    start = 1'b1;
    tick(3);
    start = 1'b0;
    tick(6);
    chk("early_active", 32'(active), 0);
    chk("early_bytes", 32'(bytes.size()), 0);

    // Basic frame, with a retrigger mid-frame that must be ignored.
    clear_log();
    trig();
    tick(2);
    chk("basic_active_hi", 32'(active), 1);
    tick(30);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_bytes(FL, 2000);
    tick(60);
    chk("basic_count", 32'(bytes.size()), FL);
    for (int i = 0; i < FL && i < bytes.size(); i++)
      chk($sformatf("basic_b%0d", i), 32'(bytes[i]), 32'(exp_byte(i)));
    chk("basic_fd_last", 32'(fds[FL-1]), 1);
    chk("basic_fd_count", fd_count(), 1);
    chk("basic_spacing", wcyc[1] - wcyc[0], 15);
    chk("basic_active_lo", 32'(active), 0);
    chk("basic_viol", viol, 0);

    // Continuous: second frame follows at the normal byte cadence.
    clear_log();
    continuous = 1'b1;
    trig();
    wait_bytes(FL + 2, 2000);
    continuous = 1'b0;
    wait_bytes(2 * FL, 2000);
    tick(60);
    chk("cont_count", 32'(bytes.size()), 2 * FL);
    for (int i = 0; i < 2 * FL && i < bytes.size(); i++)
      chk($sformatf("cont_b%0d", i), 32'(bytes[i]), 32'(exp_byte(i % FL)));
    chk("cont_fd1", 32'(fds[FL-1]), 1);
    chk("cont_fd2", 32'(fds[2*FL-1]), 1);
    chk("cont_fd_count", fd_count(), 2);
    chk("cont_gap", wcyc[FL] - wcyc[FL-1], 15);
    chk("cont_active_lo", 32'(active), 0);
    chk("cont_viol", viol, 0);

    // Abort after the fifth pixel byte, then a clean restart.
    clear_log();
    trig();
    wait_bytes(HN + 5, 2000);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick(60);
    chk("abort_count", 32'(bytes.size()), HN + 5);
    chk("abort_fd_count", fd_count(), 0);
    chk("abort_active", 32'(active), 0);
    trig();
    wait_bytes(HN + 5 + FL, 2000);
    tick(40);
    chk("abort_restart_count", 32'(bytes.size()), HN + 5 + FL);
    for (int i = 0; i < FL && (HN + 5 + i) < bytes.size(); i++)
      chk($sformatf("restart_b%0d", i), 32'(bytes[HN+5+i]), 32'(exp_byte(i)));
    chk("restart_fd_count", fd_count(), 1);
    chk("abort_viol", viol, 0);

    // Synchronous reset in the middle of a frame.
    clear_log();
    trig();
    wait_bytes(HN + 3, 2000);
    tick(7);
    chk("pre_rst_read_x", 32'(read_x), 3);
    chk("pre_rst_active", 32'(active), 1);
    reset = 1'b1;
    tick();
    chk("mid_rst_tx_write", 32'(tx_write), 0);
    chk("mid_rst_read_xy", {28'd0, read_y, read_x}, 0);
    chk("mid_rst_active", 32'(active), 0);
    chk("mid_rst_tx_data", 32'(tx_data), 0);
    reset = 1'b0;
    tick(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_dump_ctrl.md
# frame_dump_ctrl

Parametrised frame-dump controller for the camera debug path. On a debounced trigger it raster-scans a downsampled frame buffer through its read port and streams each pixel byte to the UART transmitter, pacing writes with a configurable post-busy holdoff. Successor to the fixed 40×30 button-triggered dump logic. Adds:
- arbitrary frame dimensions and read latency;
- continuous (repeat) mode;
- abort;
- completion pulse;
- optional framing header.

It sits in the `clk12` domain between the `downsample` read port and `uart`.

## Interface
Parameters:
- `WIDTH`, 40, pixels per line, 1..255.
- `HEIGHT`, 30, lines per frame, 1..255.
- `X_BITS`, 6, width of `read_x`; must satisfy 2^X_BITS ≥ WIDTH.
- `Y_BITS`, 5, width of `read_y`; must satisfy 2^Y_BITS ≥ HEIGHT.
- `READ_LATENCY`, 1, cycles from address to valid `read_data`, 1..4.
- `HOLDOFF`, 8191, idle cycles required after `tx_busy` falls before next write, 1..65535.
- `DEBOUNCE`, 16383, cycles `start` must be low before a rising edge is accepted.

Ports:
- `clock`  in  1  system clock (`clk12`).
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  raw trigger (button level), synchronised internally.
- `continuous`  in  1  when high at frame end, the next frame starts immediately.
- `abort`  in  1  returns the block to IDLE.
- `read_x`  out  X_BITS  frame buffer column address.
- `read_y`  out  Y_BITS  frame buffer row address.
- `read_data`  in  8  frame buffer data.
- `tx_busy`  in  1  UART busy.
- `tx_write`  out  1  one-cycle byte strobe.
- `tx_data`  out  8  byte to transmit; valid while `tx_write` is high.
- `active`  out  1  high from trigger acceptance until return to IDLE.
- `frame_done`  out  1  one-cycle pulse after the last byte of a frame is written.

## Operation
- **Trigger:**
  - `start` is registered once.
  - Debounce counter: cleared while the registered `start` is high; counts up while it is low; saturates at `DEBOUNCE`.
  - A trigger is accepted when the registered `start` is high, the counter is saturated and state is IDLE.
  - `start` is ignored in all other states.
- **Holdoff counter:**
  - Cleared on any cycle where `tx_busy` or `tx_write` is high.
  - Otherwise increments, saturating at `HOLDOFF`.
  - `ready` = counter saturated, `tx_busy` low and `tx_write` low.
- **States:**
  - IDLE: on trigger, set x = y = 0 and go to HDR (macro on) or FETCH (macro off).
  - HDR: emit the header bytes in order, one per `ready` cycle, then go to FETCH.
  - FETCH: `read_x`/`read_y` hold the current address; wait `READ_LATENCY` cycles, then latch `read_data` into `tx_data` and go to SEND.
  - SEND: when `ready`, pulse `tx_write` and advance the address:
    - If x = WIDTH−1: x ← 0, y ← y+1; otherwise x ← x+1.
    - If the byte just written was (WIDTH−1, HEIGHT−1): pulse `frame_done`, reset the address to (0,0), and go to HDR/FETCH if `continuous` is high, otherwise IDLE.
    - Otherwise go to FETCH.
- **Abort:**
  - `abort` high in any state → IDLE on the next edge.
  - `tx_write` is suppressed in that cycle and no `frame_done` is generated.
  - `abort` has priority over every other transition.
- **Address range:** the address never leaves [0,WIDTH−1]×[0,HEIGHT−1].
- **Bytes per frame:** exactly WIDTH×HEIGHT pixel bytes, plus 4 when the header is enabled.

## Timing
- **Reset values:**
  - `read_x`, `read_y`, `tx_write`, `tx_data`, `active`, `frame_done` = 0.
  - State = IDLE.
  - Debounce and holdoff counters = 0, so no trigger is accepted for `DEBOUNCE` cycles after reset.
- **`active`:** registered; rises the cycle after trigger acceptance.
- **Write spacing:** minimum spacing between `tx_write` pulses is `READ_LATENCY`+1 cycles, and never less than `HOLDOFF`+1 cycles after the cycle in which `tx_busy` was last high.
- **`tx_write` legality:** never asserted while `tx_busy` is high, nor in two consecutive cycles.
- **`frame_done` / final `tx_write`:** `frame_done` coincides with the final `tx_write`.
- **Mid-frame reset:** all outputs return to reset values on the next edge.

## Configuration
- Macro `FRAME_DUMP_HEADER_EN`.
- **Defined:** each frame is prefixed by `8'hFF`, `8'h00`, `WIDTH`, `HEIGHT`. Pixel bytes equal to `8'hFF` are transmitted as `8'hFE`, so `8'hFF` only ever marks a frame start.
- **Undefined:** no HDR state; pixel bytes are sent unmodified.

## Structure
- **Package `frame_dump_pkg`:**
  - state enum (IDLE, HDR, FETCH, SEND);
  - header constants `SYNC0 = 8'hFF`, `SYNC1 = 8'h00`;
  - clip value `8'hFE`.
- **Sub-module `trigger_debounce`:** input register, saturating low-time counter, accept output; gated by IDLE at the parent.
- The holdoff counter and FSM stay in the parent.

## Test plan
Common parameters: WIDTH=4, HEIGHT=3, HOLDOFF=3, DEBOUNCE=7, READ_LATENCY=1. Buffer model returns `{y,x}` nibbles; UART model holds busy for 10 cycles after each write.
- **Basic frame:** hold `start` low 8 cycles, pulse it high → 12 writes with bytes 00,01,02,03,10,…,23; `frame_done` on the 12th write; `active` falls to 0; each write ≥4 cycles after busy falls.
- **Debounce:** assert `start` 3 cycles after reset → no trigger; a retrigger while `active` → ignored, still exactly 12 bytes.
- **Continuous:** `continuous`=1 → second frame starts with 00 immediately after `frame_done`; deasserted during frame 2 → IDLE after its byte 23.
- **Abort:** `abort` at byte 5 → no further `tx_write`, no `frame_done`; next trigger restarts at 00.
- **Header** (`FRAME_DUMP_HEADER_EN`, model returns FF at (1,0)) → bytes FF,00,04,03,00,FE,…; reset asserted mid-frame → `tx_write`=0 and address (0,0) next cycle.
